// File: rtl/user_select_input_pkg.sv
// user_select_input_pkg: shared FSM encodings, default debounce length and selection helper
package user_select_input_pkg;
    typedef enum logic {ST_SELECT = 1'b0, ST_LOCKED = 1'b1} state_t;
    localparam int DEBOUNCE_DEFAULT = 500000;
    function automatic logic [1:0] next_user(input logic [1:0] u, input int n);
        return (u == 2'(n - 1)) ? 2'd0 : u + 2'd1;
    endfunction
endpackage

// File: rtl/user_select_input_button_debounce.sv
// button_debounce: synchronizes, debounces and edge-detects one raw pushbutton
module button_debounce
    import user_select_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            cnt       <= '0;
            btn_level <= 1'b0;
            level_d   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_raw};
            level_d   <= btn_level;
            btn_pulse <= btn_level & ~level_d;
            if (sync[1] == btn_level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_level <= sync[1];
                cnt       <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/user_select_input.sv
// user_select_input: debounced next/lock buttons driving a lockable 2-bit user selection
module user_select_input
    import user_select_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int NUM_USERS       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_lock,
    output logic [1:0] user,
    output logic       locked,
    output logic       next_pulse
);
    logic   next_level, lock_level, lock_pulse;
    state_t state;
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .btn_raw(btn_next), .btn_level(next_level), .btn_pulse(next_pulse)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lock (
        .clk(clk), .rst(rst), .btn_raw(btn_lock), .btn_level(lock_level), .btn_pulse(lock_pulse)
    );
    // a press strobe can only occur while its debounced level is still high
    always_comb assert (rst || ((!next_pulse || next_level) && (!lock_pulse || lock_level)));
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_SELECT;
            user   <= '0;
            locked <= 1'b0;
        end else if (lock_pulse) begin
            state  <= (state == ST_SELECT) ? ST_LOCKED : ST_SELECT;
            locked <= (state == ST_SELECT);
        end else if (next_pulse && state == ST_SELECT)
            user <= next_user(user, NUM_USERS);
    end
endmodule

// File: tb/tb_user_select_input.sv
// tb_user_select_input: randomized + directed scoreboard bench against a window-based button model
module tb_user_select_input;
    localparam int D = 4;
    logic clk = 0, rst = 1, btn_next = 0, btn_lock = 0;
    logic [1:0] user4, user3;
    logic locked4, locked3, np4, np3;

    user_select_input #(.DEBOUNCE_CYCLES(D), .NUM_USERS(4)) dut4 (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_lock(btn_lock),
        .user(user4), .locked(locked4), .next_pulse(np4)
    );
    user_select_input #(.DEBOUNCE_CYCLES(D), .NUM_USERS(3)) dut3 (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_lock(btn_lock),
        .user(user3), .locked(locked3), .next_pulse(np3)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit sn [0:16383];
    bit sl [0:16383];
    int e = 0;
    bit lvn, lvl, ml;
    int lfn, lfl, mu4, mu3;
    typedef struct { int t; int u; bit l; } chg_t;
    int   pq [$];
    chg_t cq4 [$];
    chg_t cq3 [$];

    // a level flips once the raw samples feeding the last D comparisons since the last flip/reset all disagree with it
    function automatic bit accept(input bit is_lock, input bit lv, input int lf);
        if (e - D + 1 <= lf) return 0;
        for (int i = e - D - 1; i <= e - 2; i++)
            if ((is_lock ? sl[i] : sn[i]) == lv) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        bit pn, pl;
        e++;
        sn[e] = btn_next & ~rst;
        sl[e] = btn_lock & ~rst;
        pn = 0;
        pl = 0;
        if (rst) begin
            lvn = 0; lvl = 0; ml = 0; mu4 = 0; mu3 = 0; lfn = e; lfl = e;
            pq.delete(); cq4.delete(); cq3.delete();
        end else begin
            if (accept(0, lvn, lfn)) begin lvn = !lvn; lfn = e; pn = lvn; end
            if (accept(1, lvl, lfl)) begin lvl = !lvl; lfl = e; pl = lvl; end
            if (pn) pq.push_back(e + 1);
            if (pl) begin
                ml = !ml;
                cq4.push_back('{e + 2, mu4, ml});
                cq3.push_back('{e + 2, mu3, ml});
            end else if (pn && !ml) begin
                mu4 = (mu4 + 1) % 4;
                mu3 = (mu3 + 1) % 3;
                cq4.push_back('{e + 2, mu4, ml});
                cq3.push_back('{e + 2, mu3, ml});
            end
        end
    end

    logic [2:0] prev4, prev3;
    always @(negedge clk) begin
        int   t;
        chg_t c;
        if (rst) begin
            prev4 = {user4, locked4};
            prev3 = {user3, locked3};
        end else begin
            checks++;
            if (np3 !== np4) begin errors++; $display("FAIL pulse_match edge %0d np4=%b np3=%b", e, np4, np3); end
            if (np4) begin
                checks++;
                if (pq.size() == 0) begin errors++; $display("FAIL pulse_unexpected edge %0d", e); end
                else begin
                    t = pq.pop_front();
                    if (t != e) begin errors++; $display("FAIL pulse_time got edge %0d want edge %0d", e, t); end
                end
            end
            if ({user4, locked4} !== prev4) begin
                checks++;
                if (cq4.size() == 0) begin errors++; $display("FAIL chg4_unexpected edge %0d user=%0d locked=%b", e, user4, locked4); end
                else begin
                    c = cq4.pop_front();
                    if (c.t != e || c.u != int'(user4) || c.l != locked4) begin
                        errors++;
                        $display("FAIL chg4 got edge %0d user %0d locked %b want edge %0d user %0d locked %b", e, user4, locked4, c.t, c.u, c.l);
                    end
                end
                prev4 = {user4, locked4};
            end
            if ({user3, locked3} !== prev3) begin
                checks++;
                if (cq3.size() == 0) begin errors++; $display("FAIL chg3_unexpected edge %0d user=%0d locked=%b", e, user3, locked3); end
                else begin
                    c = cq3.pop_front();
                    if (c.t != e || c.u != int'(user3) || c.l != locked3) begin
                        errors++;
                        $display("FAIL chg3 got edge %0d user %0d locked %b want edge %0d user %0d locked %b", e, user3, locked3, c.t, c.u, c.l);
                    end
                end
                prev3 = {user3, locked3};
            end
            checks++;
            if (user3 >= 2'd3) begin errors++; $display("FAIL mod3_range user=%0d", user3); end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin errors++; $display("FAIL %s got %0d want %0d", name, got, exp); end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic press_next(input int hi, input int lo);
        btn_next = 1; cyc(hi); btn_next = 0; cyc(lo);
    endtask

    task automatic press_lock(input int hi, input int lo);
        btn_lock = 1; cyc(hi); btn_lock = 0; cyc(lo);
    endtask

    initial begin
        int exp3 [4] = '{1, 2, 0, 1};
        cyc(3);
        rst = 0;
        cyc(5);
        chk("reset_user", user4, 0);
        // cycle and wrap
        for (int i = 0; i < 5; i++) begin
            press_next(10, 10);
            chk("wrap_user4", user4, (i + 1) % 4);
        end
        chk("wrap_user3", user3, 2);
        // reset with buttons held, then next still held after release
        btn_next = 1; btn_lock = 1; rst = 1;
        cyc(1);
        chk("rst_user", user4, 0);
        chk("rst_locked", locked4, 0);
        chk("rst_pulse", np4, 0);
        cyc(2);
        rst = 0; btn_lock = 0;
        cyc(7);
        chk("held_before", user4, 0);
        cyc(1);
        chk("held_after", user4, 1);
        btn_next = 0;
        cyc(12);
        // bounce then hold, then a too-short pulse
        for (int i = 0; i < 4; i++) begin btn_next = (i % 2 == 0); cyc(1); end
        btn_next = 1; cyc(12); btn_next = 0; cyc(12);
        chk("bounce_user", user4, 2);
        btn_next = 1; cyc(3); btn_next = 0; cyc(12);
        chk("short_user", user4, 2);
        // lock behaviour
        press_lock(10, 10);
        chk("lock_on", locked4, 1);
        repeat (3) press_next(10, 10);
        chk("lock_hold_user", user4, 2);
        press_lock(10, 10);
        chk("lock_off", locked4, 0);
        press_next(10, 10);
        chk("unlock_user", user4, 3);
        // simultaneous presses from user=1
        press_next(10, 10);
        press_next(10, 10);
        btn_next = 1; btn_lock = 1; cyc(10); btn_next = 0; btn_lock = 0; cyc(10);
        chk("simul_locked", locked4, 1);
        chk("simul_user", user4, 1);
        press_lock(10, 10);
        // modulus 3 sequence from reset
        rst = 1; cyc(3); rst = 0; cyc(3);
        for (int i = 0; i < 4; i++) begin
            press_next(10, 10);
            chk("mod3_user", user3, exp3[i]);
        end
        // randomized button activity
        repeat (300) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_lock = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 12));
        end
        btn_next = 0; btn_lock = 0;
        cyc(30);
        chk("pulse_q_empty", pq.size(), 0);
        chk("chg4_q_empty", cq4.size(), 0);
        chk("chg3_q_empty", cq3.size(), 0);
        chk("final_user4", user4, mu4);
        chk("final_locked4", locked4, ml);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/user_select_input.md
# user_select_input

Upstream input stage for the four-value display: turns two raw pushbuttons into a stable 2-bit user selection. A "next" button cycles the selection 0→1→2→3→0; a "lock" button freezes or unfreezes it. `user` drives the display's 2-bit `user` input directly, and `locked` is available to downstream logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000, is the number of consecutive stable clock cycles required to accept a button level change (10 ms at 50 MHz). Minimum 2.
- `NUM_USERS`, default 4, is the selection modulus. Legal range 2..4.

Ports:
- `clk`, input, 1 bit: the single clock; all logic is on the rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `btn_next`, input, 1 bit: raw, asynchronous, active-high "next" button.
- `btn_lock`, input, 1 bit: raw, asynchronous, active-high "lock" button.
- `user`, output, 2 bits: current selection, registered.
- `locked`, output, 1 bit: 1 while the selection is frozen, registered.
- `next_pulse`, output, 1 bit: one-cycle strobe on each accepted next press, including presses ignored while locked.

## Operation
- **Per-button path** (identical for both buttons):
  - Two-flop synchronizer.
  - Debounce counter. It counts while the synchronized level differs from the debounced level, and clears to 0 whenever they match.
  - When the count reaches `DEBOUNCE_CYCLES`-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - A rising edge of the debounced level produces a 1-cycle press pulse. Releases produce nothing.
- **FSM states:** SELECT and LOCKED.
  - SELECT, next pulse: `user` ← (`user`+1) mod `NUM_USERS`. Wrap is `NUM_USERS`-1 → 0.
  - SELECT, lock pulse: go to LOCKED; `user` is unchanged.
  - LOCKED, next pulse: ignored; `user` holds.
  - LOCKED, lock pulse: go to SELECT.
  - Next and lock pulses in the same cycle: lock wins and `user` does not change.
- **Outputs:** `locked` = (state == LOCKED), registered. `user` never takes a value ≥ `NUM_USERS`.
- **Reset values** (on any cycle where `rst`=1, including mid-debounce or mid-count): `user`=0, `locked`=0, `next_pulse`=0, state SELECT, synchronizers 0, debounced levels 0, counters 0.
  - A button still held when reset releases is seen as a fresh press once `DEBOUNCE_CYCLES` has elapsed.
- **Bounce filtering:** any glitch shorter than `DEBOUNCE_CYCLES` cycles resets the counter and has no effect.

## Timing
- Edge numbering: raw button goes high before edge k and stays high. Then:
  - Synchronized level is 1 after edge k+1.
  - Debounced level is 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - Press pulse (and `next_pulse`) is high for exactly the one cycle following edge k+2+`DEBOUNCE_CYCLES`.
  - `user`/`locked` update at edge k+3+`DEBOUNCE_CYCLES`.
- **Latency:** `DEBOUNCE_CYCLES`+3 cycles from press to output change.
- **Release:** an accepted release takes `DEBOUNCE_CYCLES`+2 cycles to register. A new press can only be accepted after that.
- **Rate limit:** at most one next and one lock press per 2×`DEBOUNCE_CYCLES` cycles.
- **Output stability:** no combinational path from inputs to outputs. `user` changes on at most one edge per accepted press.

## Structure
- Shared include (the team's Verilog definitions file): FSM state encodings `ST_SELECT`=1'b0 and `ST_LOCKED`=1'b1, and the default debounce constant.
- Sub-module `button_debounce`: synchronizer, counter, debounced level and rising-edge pulse. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `btn_level`, `btn_pulse`. It is instantiated twice.
- The top level contains only the FSM and the selection counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `NUM_USERS`=4.
1. **Reset:** assert `rst` with buttons high → `user`=0, `locked`=0, `next_pulse`=0 on the next edge. Release `rst` with `btn_next` held → `user`=1 exactly 7 cycles later.
2. **Cycle and wrap:** five clean next presses, each 10 cycles high and 10 low → `user` reads 1, 2, 3, 0, 1. `next_pulse` is high for exactly one cycle, 6 cycles after each press.
3. **Bounce:** `btn_next` toggled 1,0,1,0,1 on single cycles, then held high → exactly one increment, 7 cycles after the final rise. A 3-cycle pulse alone → no change.
4. **Lock:** from `user`=2, lock press → `locked`=1. Then three next presses → `user` stays 2 and `next_pulse` fires 3 times. Second lock press → `locked`=0. Next press → `user`=3.
5. **Simultaneous:** `btn_next` and `btn_lock` rise on the same cycle from `user`=1, SELECT → `locked`=1, `user`=1.
6. **Modulus:** with `NUM_USERS`=3, four next presses → `user` reads 1, 2, 0, 1 and never 3.
